// File: rtl/rd3_commutator.sv
// Input reorder stage ahead of the radix-3 butterfly: buffers the first two
// thirds of each 3*STRIDE block and emits x[p], x[p+M], x[p+2M] in parallel.
module rd3_commutator #(
  parameter int SIGN_BIT = 1,
  parameter int INT_BIT  = 6,
  parameter int FLT_BIT  = 6,
  parameter int STRIDE   = 4,
  parameter int D_SIZE   = SIGN_BIT + INT_BIT + FLT_BIT
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              di_vld,
  input  logic              di_sop,
  input  logic [D_SIZE-1:0] di_re,
  input  logic [D_SIZE-1:0] di_im,
  output logic              do_vld,
  output logic              do_last,
  output logic [D_SIZE-1:0] out1_re,
  output logic [D_SIZE-1:0] out1_im,
  output logic [D_SIZE-1:0] out2_re,
  output logic [D_SIZE-1:0] out2_im,
  output logic [D_SIZE-1:0] out3_re,
  output logic [D_SIZE-1:0] out3_im
);

  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [PW-1:0] POS_LAST = PW'(STRIDE - 1);

  typedef enum logic [1:0] {
    SEG_A    = 2'd0,
    SEG_B    = 2'd1,
    SEG_EMIT = 2'd2
  } seg_t;

  typedef logic [2*D_SIZE-1:0] word_t;

  seg_t          seg_q;
  seg_t          seg_eff;
  seg_t          seg_next;
  logic [PW-1:0] pos_q;
  logic [PW-1:0] pos_eff;
  logic          pos_wrap;
  logic          emit;

  word_t din;
  word_t buf_a [STRIDE];
  word_t buf_b [STRIDE];
  word_t o1_q, o2_q, o3_q;

  assign din = {di_re, di_im};

  // A valid start-of-block forces this sample to idx 0 regardless of the count.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    seg_eff = seg_q;
    pos_eff = pos_q;
    if (di_sop) begin
      seg_eff = SEG_A;
      pos_eff = '0;
    end
  end

  assign pos_wrap = (pos_eff == POS_LAST);
  assign emit     = di_vld && (seg_eff == SEG_EMIT);

  always_comb begin
    seg_next = seg_eff;
    if (pos_wrap) begin
      case (seg_eff)
        SEG_A:   seg_next = SEG_B;
        SEG_B:   seg_next = SEG_EMIT;
        default: seg_next = SEG_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      seg_q <= SEG_A;
      pos_q <= '0;
    end else if (di_vld) begin
      seg_q <= seg_next;
      pos_q <= pos_wrap ? '0 : pos_eff + 1'b1;
    end
  end

  // NOTE: the sample buffers are plain storage with no reset, so they can map to RAM;
  // each entry is always rewritten in the current block before it is read.
  always_ff @(posedge clk) begin
    if (di_vld && (seg_eff == SEG_A)) buf_a[pos_eff] <= din;
    if (di_vld && (seg_eff == SEG_B)) buf_b[pos_eff] <= din;
  end

  // Outputs are registered, so an A[0] write right after the last triple cannot disturb it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      do_vld  <= 1'b0;
      do_last <= 1'b0;
      o1_q    <= '0;
      o2_q    <= '0;
      o3_q    <= '0;
    end else begin
      do_vld  <= emit;
      do_last <= emit && pos_wrap;
      if (emit) begin
        o1_q <= buf_a[pos_eff];
        o2_q <= buf_b[pos_eff];
        o3_q <= din;
      end
    end
  end

  assign {out1_re, out1_im} = o1_q;
  assign {out2_re, out2_im} = o2_q;
  assign {out3_re, out3_im} = o3_q;

endmodule

// File: tb/tb_rd3_commutator.sv
// Scoreboard bench for rd3_commutator: a sample-index model predicts each
// triple at capture time; a negedge monitor pops and compares on do_vld.
module tb_rd3_commutator;

  localparam int S = 4;
  localparam int D = 13;
  localparam int N = 3 * S;
  localparam int W = 6 * D + 1;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         di_vld = 1'b0;
  logic         di_sop = 1'b0;
  logic [D-1:0] di_re = '0;
  logic [D-1:0] di_im = '0;
  logic         do_vld, do_last;
  logic [D-1:0] out1_re, out1_im, out2_re, out2_im, out3_re, out3_im;

  rd3_commutator #(
    .SIGN_BIT(1), .INT_BIT(6), .FLT_BIT(6), .STRIDE(S)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .di_vld  (di_vld),
    .di_sop  (di_sop),
    .di_re   (di_re),
    .di_im   (di_im),
    .do_vld  (do_vld),
    .do_last (do_last),
    .out1_re (out1_re),
    .out1_im (out1_im),
    .out2_re (out2_re),
    .out2_im (out2_im),
    .out3_re (out3_re),
    .out3_im (out3_im)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;   // {x[p], x[p+S], x[p+2S], last}, each x = {re, im}
    time          t_cap;
  } exp_t;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  int           vld_count = 0;
  logic [2*D-1:0] blk [N];
  int           idx = 0;
  logic [W-2:0] last_out = '0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: position within the block decides buffering or emission.
  task automatic model(input logic sop, input logic [D-1:0] re, input logic [D-1:0] im);
    exp_t e;
    if (sop) idx = 0;
    blk[idx] = {re, im};
    if (idx >= 2 * S) begin
      e.data  = {blk[idx-2*S], blk[idx-S], re, im, (idx == N - 1)};
      e.t_cap = $time;
      sb.push_back(e);
    end
    idx = (idx + 1) % N;
  endtask

  task automatic send(input logic vld, input logic sop, input logic [D-1:0] re, input logic [D-1:0] im);
    di_vld = vld;
    di_sop = sop;
    di_re  = re;
    di_im  = im;
    @(posedge clk);
    if (n_rst && vld) model(sop, re, im);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 1'($urandom), D'($urandom), D'($urandom));
  endtask

  function automatic logic [D-1:0] enc(input int v);
    return D'(v * 64);
  endfunction

  // Assert reset just after a monitor sample, drive junk while held, release mid-cycle.
  task automatic apply_reset(input int cycles);
    @(negedge clk);
    #1;
    n_rst = 1'b0;
    check("sb_empty_at_reset", 96'(sb.size()), 96'd0);
    sb.delete();
    idx = 0;
    repeat (cycles) begin
      di_vld = 1'b1;
      di_sop = 1'($urandom);
      di_re  = D'($urandom);
      di_im  = D'($urandom);
      @(posedge clk);
    end
    #3;
    n_rst  = 1'b1;
    di_vld = 1'b0;
    di_sop = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [W-1:0] act;
    act = {out1_re, out1_im, out2_re, out2_im, out3_re, out3_im, do_last};
    if (!n_rst) begin
      last_out = '0;
      check("reset_outputs", 96'({act, do_vld}), 96'd0);
    end else if (do_vld) begin
      vld_count++;
      check("expected_available", 96'(sb.size() != 0), 96'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("triple", 96'(act), 96'(e.data));
        check("latency", 96'($time - e.t_cap), 96'd5);
        last_out = e.data[W-1:1];
      end
    end else begin
      check("idle_hold", 96'(act), 96'({last_out, 1'b0}));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int c;
    int vals [4];
    vals = '{-62, 62, 33, -1};

    // Reset held with live random traffic, released mid-cycle.
    n_rst = 1'b0;
    repeat (5) begin
      di_vld = 1'b1;
      di_sop = 1'($urandom);
      di_re  = D'($urandom);
      di_im  = D'($urandom);
      @(posedge clk);
    end
    #3;
    n_rst  = 1'b1;
    di_vld = 1'b0;
    di_sop = 1'b0;
    idx    = 0;

    // First block after reset needs no sop; nothing until sample 2S+1.
    v0 = vld_count;
    repeat (2 * S) send(1'b1, 1'b0, D'($urandom), D'($urandom));
    idle(1);
    check("no_vld_before_2S+1", 96'(vld_count - v0), 96'd0);
    send(1'b1, 1'b0, D'($urandom), D'($urandom));
    idle(1);
    check("first_vld_at_2S+1", 96'(vld_count - v0), 96'd1);
    repeat (S - 1) send(1'b1, 1'b0, D'($urandom), D'($urandom));
    idle(2);

    // Continuous ramp block.
    v0 = vld_count;
    for (int k = 0; k < N; k++) send(1'b1, k == 0, enc(k), enc(k));
    idle(2);
    check("ramp_vld_count", 96'(vld_count - v0), 96'd4);

    // Gapped input, two back-to-back blocks.
    v0 = vld_count;
    c = 0;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < N; k++) begin
        while (!((c % 4 == 0) || (c % 4 == 3))) begin
          idle(1);
          c++;
        end
        send(1'b1, k == 0, enc(k), enc(k));
        c++;
      end
    end
    idle(2);
    check("gapped_vld_count", 96'(vld_count - v0), 96'd8);

    // Boundary values rotated through every segment on both re and im.
    for (int k = 0; k < N; k++)
      send(1'b1, k == 0, enc(vals[(k + k / S) % 4]), enc(vals[(k + 3 * (k / S) + 1) % 4]));
    idle(2);

    // sop at idx 9 abandons the block; the new one is 20..31.
    v0 = vld_count;
    for (int k = 0; k < 9; k++) send(1'b1, k == 0, enc(k), enc(k));
    for (int k = 20; k < 32; k++) send(1'b1, k == 20, enc(k), enc(k));
    idle(2);
    check("sop_restart_vld_count", 96'(vld_count - v0), 96'd5);

    // Reset pulsed in seg 1, then a fresh block with no sop.
    for (int k = 0; k < 6; k++) send(1'b1, k == 0, enc(k), enc(k));
    apply_reset(2);
    v0 = vld_count;
    for (int k = 0; k < N; k++) send(1'b1, 1'b0, enc(40 + k), enc(-k));
    idle(2);
    check("post_reset_vld_count", 96'(vld_count - v0), 96'd4);

    // Random traffic with gaps and occasional mid-block sop.
    repeat (400)
      send(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), D'($urandom), D'($urandom));

    idle(3);
    check("scoreboard_drained", 96'(sb.size()), 96'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
